// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Brief    : Pipeline control for the MIPS-DLX core. Decides each cycle
//            whether the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB
//            latches capture, hold or take a bubble. It covers load-use
//            hazards, taken-branch flushes, multi-cycle MDU holds and
//            memory-wait freezes, and counts front-end stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl #(
    parameter int MDU_CYCLES = 4,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               ex_mem_read,
    input  logic [4:0]         ex_rt,
    input  logic               ex_branch_taken,
    input  logic               ex_mdu_start,
    input  logic               mem_wait,
    output logic               pc_enable,
    output logic               ifid_enable,
    output logic               idex_enable,
    output logic               exmem_enable,
    output logic               memwb_enable,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               exmem_bubble,
    output logic               mdu_busy,
    output logic [COUNT_W-1:0] stall_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W    = $clog2(MDU_CYCLES) + 1;
    // The entry cycle is the first hold cycle, so the MDU state only has to
    // account for the remaining MDU_CYCLES-1 of them.
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MDU_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [COUNT_W-1:0] c_STALL_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] c_STALL_MAX = {COUNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_MDU = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // State and combinational decisions
    // ------------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_mdu_cnt;
    logic [c_CNT_W-1:0]   w_mdu_cnt_nxt;
    logic                 r_mdu_busy;
    logic                 w_mdu_busy_nxt;
    logic [COUNT_W-1:0]   r_stall_count;

    logic                 w_load_use;
    logic                 w_pc_enable;
    logic                 w_ifid_enable;
    logic                 w_idex_enable;
    logic                 w_exmem_enable;
    logic                 w_memwb_enable;
    logic                 w_ifid_flush;
    logic                 w_idex_bubble;
    logic                 w_exmem_bubble;

    // Load in EX writes a register that the instruction in ID reads; r0 never
    // creates a dependency because it is hard-wired to zero.
    always_comb begin
        w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                     ((id_uses_rs && (id_rs == ex_rt)) ||
                      (id_uses_rt && (id_rt == ex_rt)));
    end

    // Next-state and latch-control decode, resolved in priority order.
    always_comb begin
        w_state_nxt    = r_state;
        w_mdu_cnt_nxt  = r_mdu_cnt;
        w_pc_enable    = 1'b1;
        w_ifid_enable  = 1'b1;
        w_idex_enable  = 1'b1;
        w_exmem_enable = 1'b1;
        w_memwb_enable = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_bubble  = 1'b0;
        w_exmem_bubble = 1'b0;

        if (!reset) begin
            // While reset is held every latch is closed and loaded with NOPs.
            w_state_nxt    = ST_RUN;
            w_mdu_cnt_nxt  = '0;
            w_pc_enable    = 1'b0;
            w_ifid_enable  = 1'b0;
            w_idex_enable  = 1'b0;
            w_exmem_enable = 1'b0;
            w_memwb_enable = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_bubble  = 1'b1;
            w_exmem_bubble = 1'b1;
        end else if (mem_wait) begin
            // Whole pipe frozen; the FSM and its counter keep their values.
            w_pc_enable    = 1'b0;
            w_ifid_enable  = 1'b0;
            w_idex_enable  = 1'b0;
            w_exmem_enable = 1'b0;
            w_memwb_enable = 1'b0;
        end else if (r_state == ST_MDU) begin
            if (r_mdu_cnt != '0) begin
                // Front end and EX hold while the MDU works; the back end
                // drains and EX/MEM receives bubbles.
                w_pc_enable    = 1'b0;
                w_ifid_enable  = 1'b0;
                w_idex_enable  = 1'b0;
                w_exmem_bubble = 1'b1;
                w_mdu_cnt_nxt  = r_mdu_cnt - c_CNT_ONE;
            end else begin
                // Release cycle: the MDU result moves on with default controls.
                w_state_nxt = ST_RUN;
            end
        end else if (ex_mdu_start) begin
            w_pc_enable    = 1'b0;
            w_ifid_enable  = 1'b0;
            w_idex_enable  = 1'b0;
            w_exmem_bubble = 1'b1;
            w_state_nxt    = ST_MDU;
            w_mdu_cnt_nxt  = c_CNT_LOAD;
        end else if (ex_branch_taken) begin
            // Both younger instructions are on the wrong path.
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
        end else if (w_load_use) begin
            // Hold the consumer in ID for one cycle behind a bubble.
            w_pc_enable   = 1'b0;
            w_ifid_enable = 1'b0;
            w_idex_bubble = 1'b1;
        end
    end

    // Busy flags the hold cycles spent inside the MDU state, excluding the
    // release cycle.
    always_comb begin
        w_mdu_busy_nxt = (w_state_nxt == ST_MDU) && (w_mdu_cnt_nxt != '0);
    end

    // FSM state, MDU countdown and registered busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_RUN;
            r_mdu_cnt  <= '0;
            r_mdu_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mdu_cnt  <= w_mdu_cnt_nxt;
            r_mdu_busy <= w_mdu_busy_nxt;
        end
    end

    // Saturating count of edges at which the PC did not advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
        end else if (!w_pc_enable && (r_stall_count != c_STALL_MAX)) begin
            r_stall_count <= r_stall_count + c_STALL_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign pc_enable    = w_pc_enable;
    assign ifid_enable  = w_ifid_enable;
    assign idex_enable  = w_idex_enable;
    assign exmem_enable = w_exmem_enable;
    assign memwb_enable = w_memwb_enable;
    assign ifid_flush   = w_ifid_flush;
    assign idex_bubble  = w_idex_bubble;
    assign exmem_bubble = w_exmem_bubble;
    assign mdu_busy     = r_mdu_busy;
    assign stall_count  = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Brief    : Directed self-checking bench for hazard_stall_ctrl, with a
//            second instance (COUNT_W=3) for stall-counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    // Control vector: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_bubble, exmem_bubble}
    localparam logic [7:0] c_DEF  = 8'b11111_000;
    localparam logic [7:0] c_LU   = 8'b00111_010;
    localparam logic [7:0] c_BR   = 8'b11111_110;
    localparam logic [7:0] c_HOLD = 8'b00011_001;
    localparam logic [7:0] c_WAIT = 8'b00000_000;
    localparam logic [7:0] c_RST  = 8'b00000_111;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_mem_read;
    logic        ex_branch_taken, ex_mdu_start, mem_wait;

    logic        pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable;
    logic        ifid_flush, idex_bubble, exmem_bubble, mdu_busy;
    logic [15:0] stall_count;

    logic        s_pc_enable, s_ifid_enable, s_idex_enable, s_exmem_enable, s_memwb_enable;
    logic        s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_mdu_busy;
    logic [2:0]  s_stall_count;

    logic [7:0]  ctl;
    assign ctl = {pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
                  ifid_flush, idex_bubble, exmem_bubble};

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MDU_CYCLES(4), .COUNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mem_wait(mem_wait),
        .pc_enable(pc_enable), .ifid_enable(ifid_enable), .idex_enable(idex_enable),
        .exmem_enable(exmem_enable), .memwb_enable(memwb_enable),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
        .mdu_busy(mdu_busy), .stall_count(stall_count)
    );

    hazard_stall_ctrl #(.MDU_CYCLES(4), .COUNT_W(3)) dut_sat (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
        .ex_mdu_start(ex_mdu_start), .mem_wait(mem_wait),
        .pc_enable(s_pc_enable), .ifid_enable(s_ifid_enable), .idex_enable(s_idex_enable),
        .exmem_enable(s_exmem_enable), .memwb_enable(s_memwb_enable),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .exmem_bubble(s_exmem_bubble),
        .mdu_busy(s_mdu_busy), .stall_count(s_stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle check: combinational controls plus registered outputs.
    task automatic chk_cyc(input string tag, input logic [7:0] exp_ctl,
                           input logic exp_busy, input int exp_stall);
        chk({tag, ".ctl"},   32'(ctl),         32'(exp_ctl));
        chk({tag, ".busy"},  32'(mdu_busy),    32'(exp_busy));
        chk({tag, ".stall"}, 32'(stall_count), 32'(exp_stall));
    endtask

    task automatic clr_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; ex_mdu_start = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        next_edge();
    endtask

    task automatic set_load_use(input logic [4:0] rs, input logic [4:0] rt_ex);
        ex_mem_read = 1'b1; ex_rt = rt_ex; id_rs = rs; id_uses_rs = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr_inputs();
        reset = 1'b0;
        #2;
        chk_cyc("reset", c_RST, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        next_edge();

        // Default behaviour after reset release
        @(negedge clk); chk_cyc("run_default", c_DEF, 1'b0, 0);
        next_edge();

        // Load-use via rs: one stall cycle
        set_load_use(5'd5, 5'd5);
        @(negedge clk); chk_cyc("lu_rs", c_LU, 1'b0, 0);
        next_edge();
        clr_inputs();
        @(negedge clk); chk_cyc("lu_cleared", c_DEF, 1'b0, 1);
        next_edge();

        // r0 never hazards
        set_load_use(5'd0, 5'd0);
        @(negedge clk); chk_cyc("lu_r0", c_DEF, 1'b0, 1);
        next_edge();

        // Source not used: no hazard
        set_load_use(5'd5, 5'd5); id_uses_rs = 1'b0;
        @(negedge clk); chk_cyc("lu_unused", c_DEF, 1'b0, 1);
        next_edge();
        clr_inputs();

        // Load-use via rt
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
        @(negedge clk); chk_cyc("lu_rt", c_LU, 1'b0, 1);
        next_edge();

        // Branch beats load-use, no stall counted
        ex_branch_taken = 1'b1;
        @(negedge clk); chk_cyc("branch_lu", c_BR, 1'b0, 2);
        next_edge();
        clr_inputs();
        @(negedge clk); chk_cyc("after_branch", c_DEF, 1'b0, 2);
        next_edge();

        // MDU op with start held high the whole time
        do_reset();
        ex_mdu_start = 1'b1;
        @(negedge clk); chk_cyc("mdu_entry", c_HOLD, 1'b0, 0);
        next_edge();
        @(negedge clk); chk_cyc("mdu_h2", c_HOLD, 1'b1, 1);
        next_edge();
        @(negedge clk); chk_cyc("mdu_h3", c_HOLD, 1'b1, 2);
        next_edge();
        @(negedge clk); chk_cyc("mdu_h4", c_HOLD, 1'b1, 3);
        next_edge();
        @(negedge clk); chk_cyc("mdu_release", c_DEF, 1'b0, 4);
        next_edge();
        ex_mdu_start = 1'b0;
        @(negedge clk); chk_cyc("mdu_after", c_DEF, 1'b0, 4);
        next_edge();

        // MDU with two wait cycles during the second hold cycle
        do_reset();
        ex_mdu_start = 1'b1;
        @(negedge clk); chk_cyc("mw_entry", c_HOLD, 1'b0, 0);
        next_edge();
        ex_mdu_start = 1'b0; mem_wait = 1'b1;
        @(negedge clk); chk_cyc("mw_wait1", c_WAIT, 1'b1, 1);
        next_edge();
        @(negedge clk); chk_cyc("mw_wait2", c_WAIT, 1'b1, 2);
        next_edge();
        mem_wait = 1'b0;
        @(negedge clk); chk_cyc("mw_h2", c_HOLD, 1'b1, 3);
        next_edge();
        @(negedge clk); chk_cyc("mw_h3", c_HOLD, 1'b1, 4);
        next_edge();
        @(negedge clk); chk_cyc("mw_h4", c_HOLD, 1'b1, 5);
        next_edge();
        @(negedge clk); chk_cyc("mw_release", c_DEF, 1'b0, 6);
        next_edge();

        // Async reset in the middle of an MDU hold
        do_reset();
        ex_mdu_start = 1'b1;
        next_edge();
        ex_mdu_start = 1'b0;
        #2 reset = 1'b0;
        #1 chk_cyc("async_rst", c_RST, 1'b0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1 chk_cyc("rst_release", c_DEF, 1'b0, 0);
        next_edge();
        set_load_use(5'd9, 5'd9);
        @(negedge clk); chk_cyc("rst_state_run", c_LU, 1'b0, 0);
        next_edge();

        // Saturation on the 3-bit counter instance
        do_reset();
        mem_wait = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next_edge();
        end
        @(negedge clk);
        chk("sat_stall", 32'(s_stall_count), 32'd7);
        chk("sat_ctl", 32'({s_pc_enable, s_memwb_enable}), 32'd0);
        chk("wide_stall", 32'(stall_count), 32'd10);
        mem_wait = 1'b0;
        next_edge();
        chk("sat_hold", 32'(s_stall_count), 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline control unit for the MIPS-DLX core: drives the `enable`, flush and bubble inputs of the PC register and the four inter-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards, flushes on taken branches, holds the front end for the multi-cycle multiply/divide unit (MDU), and freezes the whole pipe on memory wait. The latches store data; this block decides, cycle by cycle, whether each one captures, holds or injects a bubble.

## Interface
Parameters:
- `MDU_CYCLES`, 4: stall cycles per MDU operation (≥1).
- `COUNT_W`, 16: width of the stall performance counter.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1 each  instruction in ID reads that source.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rt`  in  5  load destination register in EX.
- `ex_branch_taken`  in  1  branch/jump resolved taken in EX.
- `ex_mdu_start`  in  1  instruction in EX is MUL/DIV.
- `mem_wait`  in  1  data or instruction memory not ready.
- `pc_enable`, `ifid_enable`, `idex_enable`, `exmem_enable`, `memwb_enable`  out  1 each  latch captures on this edge.
- `ifid_flush`  out  1  IF/ID loads a NOP.
- `idex_bubble`  out  1  ID/EX loads a NOP.
- `exmem_bubble`  out  1  EX/MEM loads a NOP.
- `mdu_busy`  out  1  FSM in MDU state.
- `stall_count`  out  COUNT_W  cycles with `pc_enable`=0.

## Operation
- FSM states: RUN, MDU. Registers: state, `mdu_cnt` (width clog2(MDU_CYCLES)+1), `stall_count`.
- All enable/flush/bubble outputs are combinational from state, `mdu_cnt` and current inputs; `mdu_busy` and `stall_count` are registered.
- Default (RUN, no event): all enables 1, flush/bubbles 0.
- Priority, highest first: reset, `mem_wait`, MDU hold, branch flush, load-use.
- `mem_wait`=1: all enables 0, flush/bubbles 0; state, `mdu_cnt` frozen; all other inputs ignored.
- MDU entry: RUN and `ex_mdu_start`=1 → this cycle `pc_enable`=`ifid_enable`=`idex_enable`=0, `exmem_bubble`=1, `memwb_enable`=1, `exmem_enable`=1; next state MDU, `mdu_cnt`←MDU_CYCLES-1.
- MDU with `mdu_cnt`>0: same hold outputs, `mdu_cnt` decrements.
- MDU with `mdu_cnt`=0: release cycle, default outputs, next state RUN. `ex_mdu_start` is ignored in MDU state.
- Branch flush (RUN, `ex_branch_taken`=1): all enables 1, `ifid_flush`=1, `idex_bubble`=1. The PC target mux is outside this block.
- Load-use (RUN): `ex_mem_read` & `ex_rt`≠0 & ((`id_uses_rs` & `id_rs`=`ex_rt`) | (`id_uses_rt` & `id_rt`=`ex_rt`)) → `pc_enable`=`ifid_enable`=0, `idex_bubble`=1, rest default. One cycle only: the bubble clears the condition on the next cycle.
- Branch and load-use together: branch wins.
- MDU start and branch together: MDU wins. This cannot occur legally and is defined only for determinism.
- `stall_count` increments at each edge where `pc_enable`=0 (including `mem_wait`) and saturates at all-ones.

## Timing
- While `reset`=0 (asynchronous): state RUN, `mdu_cnt`=0, `mdu_busy`=0, `stall_count`=0. All enables are 0, `ifid_flush`=`idex_bubble`=`exmem_bubble`=1.
- First edge after `reset` rises: default RUN behaviour.
- Load-use costs exactly 1 stall cycle; a taken branch costs 2 flushed slots and 0 stall cycles.
- An MDU op holds the front end for exactly MDU_CYCLES cycles (entry cycle plus MDU_CYCLES-1 in MDU). The instruction stays in EX for MDU_CYCLES+1 cycles, and `mdu_busy` is high for MDU_CYCLES-1 cycles.
- `mem_wait` during MDU extends the hold one cycle per wait cycle. The counter does not decrement.
- Reset asserted mid-MDU aborts immediately to RUN with the reset output values.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rt`=5, `id_rs`=5, `id_uses_rs`=1 → for 1 cycle `pc_enable`=`ifid_enable`=0 and `idex_bubble`=1. Same stimulus with `ex_rt`=0 or `id_uses_rs`=0 gives no stall.
- Branch: `ex_branch_taken`=1 with a load-use also true → `ifid_flush`=`idex_bubble`=1, all enables 1, `stall_count` unchanged.
- MDU with MDU_CYCLES=4: `ex_mdu_start` held high → `pc_enable`=0 for exactly 4 cycles, `exmem_bubble`=1 for those 4, `mdu_busy`=1 for 3 cycles, then release. `stall_count`=4.
- `mem_wait`=1 for 2 cycles during the second MDU hold cycle → the hold lasts 6 cycles, all enables are 0 during the wait cycles, and `stall_count`=6.
- Async reset: drop `reset` mid-MDU between edges → outputs take their reset values immediately. After release, the next cycle shows all enables 1 and state RUN.
- Saturation with COUNT_W=3: hold `mem_wait` for 10 cycles → `stall_count` stops at 7.
